// File: rtl/fmadd_pkg.sv
// Shared constants for the FMADD datapath: default bfloat16 field widths,
// exponent bias, all-ones exponent value and the bit order of the result flags.
package fmadd_pkg;

    localparam int FMADD_EXP_W = 8;
    localparam int FMADD_MAN_W = 7;
    localparam int FMADD_BIAS  = (2 ** (FMADD_EXP_W - 1)) - 1;

    // Default raw-sum underflow limit: bias minus the significand width
    // (including the hidden bit).
    localparam int FMADD_UF_LIMIT = FMADD_BIAS - (FMADD_MAN_W + 1);

    // Exponent field value that encodes Inf/NaN.
    localparam logic [FMADD_EXP_W-1:0] FMADD_EXP_ONES = '1;

    // Bit positions inside the flag vector carried through stage 2.
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_SPEC = 1;
    localparam int FLAG_UF   = 2;
    localparam int FLAG_OF   = 3;
    localparam int FLAG_W    = 4;

endpackage : fmadd_pkg

// File: rtl/fmadd_pipe_reg.sv
// Generic valid/ready register slice with a synchronous flush.
// The slice accepts whenever it is empty or its content is leaving this cycle,
// so a chain of slices sustains one transfer per clock with full backpressure.
module fmadd_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         v_q;
    logic         v_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Slice can take new data when empty or when its current content is consumed.
    always_comb begin
        in_ready = (!v_q) || out_ready;
    end

    // Next-state: flush drops everything, otherwise load on advance, otherwise hold.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush) begin
            v_d    = 1'b0;
            data_d = data_q;
        end else if (in_ready) begin
            v_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end else begin
                data_d = data_q;
            end
        end else begin
            v_d    = v_q;
            data_d = data_q;
        end
    end

    // State register; reset clears both the valid bit and the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign out_valid = v_q;
    assign out_data  = data_q;

endmodule : fmadd_pipe_reg

// File: rtl/fmadd_exponent_add_pipe.sv
// Exponent/sign stage of the FMADD datapath (bfloat16 by default).
// Stage 1 registers the raw biased-exponent sum, the product sign, zero/special
// detection and the tag; stage 2 registers the unbiased result exponent with
// underflow/overflow flags. Two fmadd_pipe_reg slices carry the handshake.
// Optional build macro FMADD_EXP_SATURATE_EN clamps out_exp on under/overflow.
module fmadd_exponent_add_pipe
    import fmadd_pkg::*;
#(
    parameter int EXP      = FMADD_EXP_W,
    parameter int MAN      = FMADD_MAN_W,
    parameter int BIAS     = FMADD_BIAS,
    parameter int UF_LIMIT = BIAS - (MAN + 1),
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP:0]     in_a,
    input  logic [EXP:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP+1:0]   out_exp,
    output logic             out_sign,
    output logic             out_zero,
    output logic             out_spec,
    output logic             out_uf,
    output logic             out_of,
    output logic [TAG_W-1:0] out_tag
);

    localparam int S1_W = TAG_W + 3 + (EXP + 1);
    localparam int S2_W = TAG_W + FLAG_W + 1 + (EXP + 2);

    localparam logic [EXP-1:0] EXP_ONES = '1;
    localparam logic [EXP+1:0] BIAS_X   = (EXP + 2)'(BIAS);
    localparam logic [EXP:0]   UF_X     = (EXP + 1)'(UF_LIMIT);
    localparam logic [EXP+1:0] OF_LIMIT = (EXP + 2)'((2 ** EXP) - 2);
`ifdef FMADD_EXP_SATURATE_EN
    localparam logic [EXP+1:0] SAT_MAX  = {2'b00, EXP_ONES};
`endif

    // Stage 1 input side
    logic [EXP-1:0]   a_exp_s;
    logic [EXP-1:0]   b_exp_s;
    logic [EXP:0]     raw_s;
    logic             sign_s;
    logic             zero_s;
    logic             spec_s;
    logic [S1_W-1:0]  s1_in_s;
    logic [S1_W-1:0]  s1_out_s;
    logic             s1_valid_s;
    logic             s2_ready_s;

    // Stage 1 register contents
    logic [TAG_W-1:0] s1_tag_s;
    logic             s1_zero_s;
    logic             s1_spec_s;
    logic             s1_sign_s;
    logic [EXP:0]     s1_raw_s;

    // Stage 2 input side
    logic [EXP+1:0]   exp_raw_s;
    logic [EXP+1:0]   exp_s;
    logic             uf_s;
    logic             of_s;
    logic [FLAG_W-1:0] flags_s;
    logic [S2_W-1:0]  s2_in_s;
    logic [S2_W-1:0]  s2_out_s;
    logic [FLAG_W-1:0] out_flags_s;

    // Stage 1 arithmetic: widened exponent sum (never wraps), sign and class detection.
    always_comb begin
        a_exp_s = in_a[EXP-1:0];
        b_exp_s = in_b[EXP-1:0];
        raw_s   = {1'b0, a_exp_s} + {1'b0, b_exp_s};
        sign_s  = in_a[EXP] ^ in_b[EXP];
        zero_s  = (a_exp_s == '0) || (b_exp_s == '0);
        spec_s  = (a_exp_s == EXP_ONES) || (b_exp_s == EXP_ONES);
        s1_in_s = {in_tag, zero_s, spec_s, sign_s, raw_s};
    end

    fmadd_pipe_reg #(
        .W (S1_W)
    ) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in_s),
        .out_valid (s1_valid_s),
        .out_ready (s2_ready_s),
        .out_data  (s1_out_s)
    );

    assign {s1_tag_s, s1_zero_s, s1_spec_s, s1_sign_s, s1_raw_s} = s1_out_s;

    // Stage 2 arithmetic: remove the bias, classify the result, optionally clamp.
    always_comb begin
        exp_raw_s = {1'b0, s1_raw_s} - BIAS_X;
        uf_s      = (s1_raw_s < UF_X);
        of_s      = ($signed(exp_raw_s) > $signed(OF_LIMIT));
`ifdef FMADD_EXP_SATURATE_EN
        if (uf_s) begin
            exp_s = '0;
        end else if (of_s) begin
            exp_s = SAT_MAX;
        end else begin
            exp_s = exp_raw_s;
        end
`else
        exp_s = exp_raw_s;
`endif
        flags_s            = '0;
        flags_s[FLAG_ZERO] = s1_zero_s;
        flags_s[FLAG_SPEC] = s1_spec_s;
        flags_s[FLAG_UF]   = uf_s;
        flags_s[FLAG_OF]   = of_s;
        s2_in_s = {s1_tag_s, flags_s, s1_sign_s, exp_s};
    end

    fmadd_pipe_reg #(
        .W (S2_W)
    ) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_ready_s),
        .in_data   (s2_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out_s)
    );

    assign {out_tag, out_flags_s, out_sign, out_exp} = s2_out_s;

    assign out_zero = out_flags_s[FLAG_ZERO];
    assign out_spec = out_flags_s[FLAG_SPEC];
    assign out_uf   = out_flags_s[FLAG_UF];
    assign out_of   = out_flags_s[FLAG_OF];

endmodule : fmadd_exponent_add_pipe

// File: tb/tb_fmadd_exponent_add_pipe.sv
// Self-checking bench for fmadd_exponent_add_pipe (bfloat16 configuration).
// A queue-based scoreboard holds the expected result of every accepted
// operation, computed with plain integer arithmetic, and is compared against
// the DUT whenever out_valid is high. Honours FMADD_EXP_SATURATE_EN.
module tb_fmadd_exponent_add_pipe;

    typedef struct packed {
        logic [9:0] exp;
        logic       sign;
        logic       zero;
        logic       spec;
        logic       uf;
        logic       of;
        logic [3:0] tag;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_a;
    logic [8:0] in_b;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_exp;
    logic       out_sign;
    logic       out_zero;
    logic       out_spec;
    logic       out_uf;
    logic       out_of;
    logic [3:0] out_tag;

    res_t dut_r;
    res_t exp_q[$];
    res_t held_r;
    bit   hold_pending = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fmadd_exponent_add_pipe #(
        .EXP      (8),
        .MAN      (7),
        .BIAS     (127),
        .UF_LIMIT (119),
        .TAG_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_spec  (out_spec),
        .out_uf    (out_uf),
        .out_of    (out_of),
        .out_tag   (out_tag)
    );

    always_comb dut_r = {out_exp, out_sign, out_zero, out_spec, out_uf, out_of, out_tag};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: exponent sum, bias removal and classification in integers.
    function automatic res_t model(input logic [8:0] a, input logic [8:0] b, input logic [3:0] tag);
        res_t r;
        int ae;
        int be;
        int raw;
        int e;
        ae = int'(a[7:0]);
        be = int'(b[7:0]);
        raw = ae + be;
        e = raw - 127;
        r.uf   = (raw < 119);
        r.of   = (e > 254);
        r.zero = (ae == 0) || (be == 0);
        r.spec = (ae == 255) || (be == 255);
        r.sign = a[8] ^ b[8];
`ifdef FMADD_EXP_SATURATE_EN
        if (r.uf) e = 0;
        else if (r.of) e = 255;
`endif
        r.exp = e[9:0];
        r.tag = tag;
        return r;
    endfunction

    function automatic logic [8:0] rand_op();
        logic [7:0] e;
        case ($urandom_range(0, 5))
            0: e = 8'h00;
            1: e = 8'hFF;
            2: e = 8'($urandom_range(50, 70));
            3: e = 8'($urandom_range(240, 254));
            default: e = 8'($urandom);
        endcase
        return {1'($urandom), e};
    endfunction

    // Scoreboard: compare, hold-stability, accept tracking, flush/reset clearing.
    always @(negedge clk) begin
        if (hold_pending) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(dut_r), 32'(held_r));
        end
        hold_pending = 1'b0;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h expected no result", dut_r);
            end else begin
                check("result", 32'(dut_r), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
            if (!out_ready && !flush && !rst) begin
                hold_pending = 1'b1;
                held_r = dut_r;
            end
        end
        if (in_valid && in_ready && !flush && !rst) exp_q.push_back(model(in_a, in_b, in_tag));
        if (flush || rst) exp_q.delete();
    end

    // Single isolated operation with exact 2-cycle latency check.
    task automatic send_one(input logic [8:0] a, input logic [8:0] b, input logic [3:0] tag);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
        @(negedge clk);
        check("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("latency1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency2_valid", 32'(out_valid), 32'd1);
    endtask

    // Back-to-back stream with out_ready low for 3 cycles mid-stream.
    task automatic stream(input int n);
        int  sent = 0;
        int  cyc = 0;
        bit  blocked = 1'b0;
        @(posedge clk); #1;
        in_a = rand_op(); in_b = rand_op(); in_tag = 4'(sent + 8);
        while (sent < n && cyc < 200) begin
            in_valid  = 1'b1;
            out_ready = !(cyc >= 3 && cyc < 6);
            @(negedge clk);
            if (!in_ready) blocked = 1'b1;
            if (in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
            if (in_ready || sent == n) begin
                in_a = rand_op(); in_b = rand_op(); in_tag = 4'(sent + 8);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", 32'(sent), 32'(n));
        check("stream_blocked", 32'(blocked), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("stream_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Stall S2, then flush or reset with an input present.
    task automatic stall_then_clear(input bit use_rst);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 9'h085; in_b = 9'h080; in_tag = 4'hA;
        @(posedge clk); #1;
        in_a = 9'h090; in_b = 9'h070; in_tag = 4'hB;
        @(posedge clk); #1;
        in_a = 9'h0A0; in_b = 9'h060; in_tag = 4'hC;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(negedge clk);
        check("stalled_valid", 32'(out_valid), 32'd1);
        check("stalled_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("clear_valid", 32'(out_valid), 32'd0);
        if (use_rst) check("clear_data", 32'(dut_r), 32'd0);
        check("clear_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("clear_s1_empty", 32'(out_valid), 32'd0);
        send_one(9'h081, 9'h082, 4'hD);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t m;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_a = 9'h000; in_b = 9'h000; in_tag = 4'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_data", 32'(dut_r), 32'd0);

        // Pin the reference model against hand-computed values.
        m = model(9'h080, 9'h17F, 4'h0);
        check("pin_exp128", 32'(m.exp), 32'd128);
        check("pin_sign", 32'(m.sign), 32'd1);
        check("pin_flags", 32'({m.zero, m.spec, m.uf, m.of}), 32'd0);
        m = model(9'h040, 9'h030, 4'h0);
        check("pin_uf", 32'(m.uf), 32'd1);
`ifdef FMADD_EXP_SATURATE_EN
        check("pin_uf_exp", 32'(m.exp), 32'h000);
`else
        check("pin_uf_exp", 32'(m.exp), 32'h3F1);
`endif
        m = model(9'h0FE, 9'h0FE, 4'h0);
        check("pin_of", 32'(m.of), 32'd1);
`ifdef FMADD_EXP_SATURATE_EN
        check("pin_of_exp", 32'(m.exp), 32'd255);
`else
        check("pin_of_exp", 32'(m.exp), 32'd381);
`endif
        m = model(9'h000, 9'h1FF, 4'h0);
        check("pin_zero_spec", 32'({m.zero, m.spec}), 32'b11);

        // Directed operations, each with latency checks.
        send_one(9'h080, 9'h17F, 4'h1);
        send_one(9'h040, 9'h030, 4'h2);
        send_one(9'h0FE, 9'h0FE, 4'h3);
        send_one(9'h000, 9'h090, 4'h4);
        send_one(9'h185, 9'h0FF, 4'h5);
        send_one(9'h000, 9'h1FF, 4'h6);
        send_one(9'h077, 9'h000, 4'h7);

        stream(8);
        stall_then_clear(1'b0);
        stall_then_clear(1'b1);

        // Randomised traffic with random backpressure and rare flushes.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            in_a = rand_op(); in_b = rand_op(); in_tag = 4'($urandom);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("final_empty", 32'(exp_q.size()), 32'd0);
        check("final_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fmadd_exponent_add_pipe
